alu_mul_seq: RTL and testbench
==============================

// Module: alu_mul_seq
// PURPOSE
//  Parametrised sequential radix-2 Booth multiplier; next-generation multiply unit of the ALU arithmetic group.
//  Supports any operand width and per-operation signed/unsigned mode, and accepts back-to-back operations.
//  Sits beside the adder/logic units; the ALU control FSM drives the start/done handshake.
// PARAMETERS
//  WIDTH   8   operand width in bits (>=2); product is 2*WIDTH bits
// PORTS
//  clk          in   1          rising-edge clock, the only clock
//  reset_n      in   1          reset, synchronous and active-low
//  start        in   1          request; sampled only when ready
//  signed_mode  in   1          1: a and b are two's complement; 0: both are unsigned
//  a            in   WIDTH      multiplicand; captured on the accepting edge
//  b            in   WIDTH      multiplier; captured on the accepting edge
//  ready        out  1          state is IDLE or DONE, so start is accepted
//  busy         out  1          state is CALC
//  product      out  2*WIDTH    result; held until the next completion
//  done         out  1          one-cycle pulse; product is valid in the same cycle
// BEHAVIOUR
//  - Reset (reset_n=0 at an edge): state=IDLE, done=0, busy=0, product=0, internal regs=0.
//    Reset mid-operation aborts the operation: no done pulse, product becomes 0.
//  - States: IDLE -> CALC on start&ready. CALC -> DONE after the last iteration. DONE -> CALC if start, else IDLE.
//  - Accept edge: internal width N=WIDTH+1.
//    M <= a extended to N bits (sign-extend if signed_mode, else zero-extend); A <= 0.
//    Q <= b extended to N bits (same rule); Q_m1 <= 0; cnt <= N.
//  - Each CALC edge: {Q[0],Q_m1}=01 gives A+M; 10 gives A-M; else A. Arithmetic is N-bit, wrap allowed.
//    Then arithmetic right shift of {A,Q,Q_m1} by 1; cnt decrements.
//  - Last iteration (cnt==1): product <= low 2*WIDTH bits of {A',Q'}; done <= 1; state <= DONE.
//  - Latency: done is high WIDTH+1 cycles after the accept edge (no early-termination build).
//    Throughput: one result per WIDTH+2 cycles with start held high.
//  - start while busy is ignored (no queueing). a, b and signed_mode may change freely after acceptance.
//  - Result is exact for all inputs, incl. -2^(W-1) * -2^(W-1) and max unsigned * max unsigned.
//  - done never coincides with busy; ready=!busy.
// CONFIGURATION
//  ALU_MUL_EARLY_TERM_EN defined:
//    In a CALC cycle, the k=cnt unscanned bits {Q[k-1:0],Q_m1} may be all equal (all remaining steps are no-ops).
//    If so, that cycle applies an arithmetic shift of k to {A,Q}, completes, and pulses done.
//    Product is bit-identical; latency is 1..WIDTH+1 cycles.
//  Undefined: fixed latency WIDTH+1; no shifter beyond the 1-bit step.
// STRUCTURE
//  alu_pkg: state localparams (ST_IDLE, ST_CALC, ST_DONE), a 2-bit state width, and the Booth op codes (NOP/ADD/SUB).
//  cnt width = $clog2(WIDTH+2), computed locally.
//  Sub-module booth_step #(N): combinational add/sub plus 1-bit arithmetic shift of {A,Q,Q_m1}.
//  Top keeps the FSM, operand registers, counter and output registers.
// TESTING
//  1 W=8 signed: a=-3, b=7, start 1 cycle -> done exactly 9 cycles later; product=16'hFFEB; done width 1 cycle.
//  2 W=8 unsigned: a=8'hFF, b=8'hFF -> product=16'hFE01.
//    Signed mode, same inputs -> product=16'h0001.
//  3 W=8 signed: a=8'h80, b=8'h80 -> product=16'h4000.
//    a=8'h80, b=8'h7F -> product=16'hC080.
//  4 Hold start high for 3 ops -> accepted only on ready edges; results back-to-back every 10 cycles; mid-op start ignored.
//  5 reset_n low 4 cycles into CALC -> product=0, done never pulses.
//    Next op after release is correct.
//  6 W=16 random signed/unsigned sweep vs reference model.
//    With ALU_MUL_EARLY_TERM_EN: b=0 -> done 1 cycle after accept; b=1 unsigned -> 2 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arithmetic group.
//   STATE_W      : width of the multiplier FSM state encoding
//   state_e      : ST_IDLE / ST_CALC / ST_DONE
//   booth_op_e   : radix-2 Booth recoding result (NOP / ADD / SUB)
//   booth_decode : maps the scanned bit pair {Q[0], Q_m1} onto a Booth op
package alu_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_op_e;

    // 01: end of a run of ones -> add; 10: start of a run -> subtract.
    function automatic booth_op_e booth_decode(input logic q0, input logic q_m1);
        booth_op_e op;
        op = BOOTH_NOP;
        if (q0 && !q_m1) begin
            op = BOOTH_SUB;
        end else if (!q0 && q_m1) begin
            op = BOOTH_ADD;
        end
        return op;
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand into the
// accumulator, followed by a 1-bit arithmetic right shift of {A, Q, Q_m1}.
// Purely combinational.
//   acc, q, q_m1 : current {A, Q, Q_m1}
//   m            : sign/zero-extended multiplicand
//   acc_next, q_next, q_m1_next : state after this iteration
module booth_step
    import alu_pkg::*;
#(
    parameter int unsigned N = 9
) (
    input  logic [N-1:0] acc,
    input  logic [N-1:0] q,
    input  logic         q_m1,
    input  logic [N-1:0] m,
    output logic [N-1:0] acc_next,
    output logic [N-1:0] q_next,
    output logic         q_m1_next
);

    logic [N-1:0] sum;

    always_comb begin
        unique case (booth_decode(q[0], q_m1))
            BOOTH_ADD: sum = acc + m;
            BOOTH_SUB: sum = acc - m;
            default:   sum = acc;
        endcase
        // Arithmetic shift of the concatenation {sum, q, q_m1}.
        acc_next  = {sum[N-1], sum[N-1:1]};
        q_next    = {sum[0], q[N-1:1]};
        q_m1_next = q[0];
    end

endmodule

// File: rtl/alu_mul_seq.sv
// Sequential radix-2 Booth multiplier with start/done handshake.
// Operands are extended to WIDTH+1 bits so one datapath serves signed and unsigned
// modes; the low 2*WIDTH bits of the final {A, Q} are the exact product.
// Ports:
//   clk, reset_n          : clock, synchronous active-low reset
//   start, signed_mode    : request (taken when ready) and operand interpretation
//   a, b                  : multiplicand / multiplier, captured on the accepting edge
//   ready, busy           : ready = !busy; busy while iterating
//   product, done         : result and its one-cycle valid pulse
// Build option: define ALU_MUL_EARLY_TERM_EN to finish as soon as all remaining
// Booth steps are no-ops (latency 1..WIDTH+1 instead of fixed WIDTH+1).
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               busy,
    output logic [2*WIDTH-1:0] product,
    output logic               done
);

    localparam int unsigned N     = WIDTH + 1;
    localparam int unsigned CNT_W = $clog2(WIDTH + 2);

    state_e           state_q;
    logic [N-1:0]     m_q;
    logic [N-1:0]     acc_q;
    logic [N-1:0]     q_q;
    logic             q_m1_q;
    logic [CNT_W-1:0] cnt_q;

    logic [N-1:0]       acc_nx;
    logic [N-1:0]       q_nx;
    logic               q_m1_nx;
    logic               finish;
    logic [2*WIDTH-1:0] result;
    logic [N-1:0]       a_ext;
    logic [N-1:0]       b_ext;

    booth_step #(
        .N (N)
    ) u_booth_step (
        .acc       (acc_q),
        .q         (q_q),
        .q_m1      (q_m1_q),
        .m         (m_q),
        .acc_next  (acc_nx),
        .q_next    (q_nx),
        .q_m1_next (q_m1_nx)
    );

    assign a_ext = {signed_mode & a[WIDTH-1], a};
    assign b_ext = {signed_mode & b[WIDTH-1], b};

`ifdef ALU_MUL_EARLY_TERM_EN
    logic [CNT_W-1:0] rem;
    logic             tail_eq;
`endif

    always_comb begin
        finish = (cnt_q == CNT_W'(1));
        result = (2*WIDTH)'({acc_nx, q_nx});
`ifdef ALU_MUL_EARLY_TERM_EN
        // After this cycle's step, rem bits {Q[rem-1:0], Q_m1} are still unscanned.
        // If they are all equal every remaining step is a pure shift, so collapse them.
        rem     = cnt_q - CNT_W'(1);
        tail_eq = 1'b1;
        for (int unsigned i = 0; i < N - 1; i++) begin
            if (CNT_W'(i) < rem) begin
                tail_eq &= (q_nx[i] == q_m1_nx);
            end
        end
        if (rem != '0 && tail_eq) begin
            finish = 1'b1;
            result = (2*WIDTH)'($signed({acc_nx, q_nx}) >>> rem);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            q_m1_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        m_q     <= a_ext;
                        acc_q   <= '0;
                        q_q     <= b_ext;
                        q_m1_q  <= 1'b0;
                        cnt_q   <= CNT_W'(N);
                        busy    <= 1'b1;
                        state_q <= ST_CALC;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    acc_q  <= acc_nx;
                    q_q    <= q_nx;
                    q_m1_q <= q_m1_nx;
                    cnt_q  <= cnt_q - CNT_W'(1);
                    if (finish) begin
                        product <= result;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready = ~busy;

endmodule

// File: tb/tb_alu_mul_seq.sv
module tb_alu_mul_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        start8, sm8, ready8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;
    logic        start16, sm16, ready16, busy16, done16;
    logic [15:0] a16, b16;
    logic [31:0] product16;

    int checks   = 0;
    int failures = 0;

    alu_mul_seq #(.WIDTH(8)) u_dut8 (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start8),
        .signed_mode (sm8),
        .a           (a8),
        .b           (b8),
        .ready       (ready8),
        .busy        (busy8),
        .product     (product8),
        .done        (done8)
    );

    alu_mul_seq #(.WIDTH(16)) u_dut16 (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start16),
        .signed_mode (sm16),
        .a           (a16),
        .b           (b16),
        .ready       (ready16),
        .busy        (busy16),
        .product     (product16),
        .done        (done16)
    );

    // Issue one 8-bit op; lat = edges from accept to done (-1 on timeout).
    task automatic run8(input logic sm, input logic [7:0] av, input logic [7:0] bv,
                        output logic [15:0] p, output int lat, output logic busy_at_done);
        @(negedge clk);
        start8 = 1'b1; sm8 = sm; a8 = av; b8 = bv;
        @(posedge clk); #1;
        start8 = 1'b0; sm8 = ~sm; a8 = ~av; b8 = ~bv;
        lat = -1; p = 'x; busy_at_done = 1'bx;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done8) begin
                lat = k; p = product8; busy_at_done = busy8;
                break;
            end
        end
    endtask

    task automatic run16(input logic sm, input logic [15:0] av, input logic [15:0] bv,
                         output logic [31:0] p, output int lat);
        @(negedge clk);
        start16 = 1'b1; sm16 = sm; a16 = av; b16 = bv;
        @(posedge clk); #1;
        start16 = 1'b0; sm16 = ~sm; a16 = ~av; b16 = ~bv;
        lat = -1; p = 'x;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (done16) begin
                lat = k; p = product16;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
        start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        checks++; if (ready8 !== 1'b1) begin failures++;
            $display("FAIL reset_ready got=%b exp=1", ready8); end
        checks++; if (busy8 !== 1'b0) begin failures++;
            $display("FAIL reset_busy got=%b exp=0", busy8); end
        checks++; if (done8 !== 1'b0) begin failures++;
            $display("FAIL reset_done got=%b exp=0", done8); end
        checks++; if (product8 !== 16'h0000) begin failures++;
            $display("FAIL reset_product8 got=%h exp=0000", product8); end
        checks++; if (product16 !== 32'h0) begin failures++;
            $display("FAIL reset_product16 got=%h exp=00000000", product16); end
    endtask

    task automatic test_signed_basic;
        logic [15:0] p; int lat; logic bd;
        run8(1'b1, 8'hFD, 8'h07, p, lat, bd);
        checks++; if (p !== 16'hFFEB) begin failures++;
            $display("FAIL m3x7_product got=%h exp=ffeb", p); end
`ifndef ALU_MUL_EARLY_TERM_EN
        checks++; if (lat != 9) begin failures++;
            $display("FAIL m3x7_latency got=%0d exp=9", lat); end
`endif
        checks++; if (bd !== 1'b0) begin failures++;
            $display("FAIL done_with_busy got=%b exp=0", bd); end
        @(posedge clk); #1;
        checks++; if (done8 !== 1'b0) begin failures++;
            $display("FAIL done_width got=%b exp=0", done8); end
    endtask

    task automatic test_extremes;
        logic [15:0] p; int lat; logic bd;
        logic        sm[5];
        logic [7:0]  av[5];
        logic [7:0]  bv[5];
        logic [15:0] ex[5];
        sm = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        av = '{8'hFF, 8'hFF, 8'h80, 8'h80, 8'h80};
        bv = '{8'hFF, 8'hFF, 8'h80, 8'h7F, 8'h7F};
        ex = '{16'hFE01, 16'h0001, 16'h4000, 16'hC080, 16'h3F80};
        for (int i = 0; i < 5; i++) begin
            run8(sm[i], av[i], bv[i], p, lat, bd);
            checks++; if (p !== ex[i]) begin failures++;
                $display("FAIL extreme_%0d product got=%h exp=%h", i, p, ex[i]); end
        end
    endtask

    task automatic test_back_to_back;
        logic        osm[3];
        logic [7:0]  oa[3];
        logic [7:0]  ob[3];
        logic [15:0] op[3];
        osm = '{1'b0, 1'b1, 1'b0};
        oa  = '{8'h0C, 8'hFE, 8'hF0};
        ob  = '{8'h0D, 8'h05, 8'h10};
        op  = '{16'h009C, 16'hFFF6, 16'h0F00};
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            start8 = (c <= 20);
            if (c % 10 == 0) begin
                sm8 = osm[c/10]; a8 = oa[c/10]; b8 = ob[c/10];
            end else begin
                sm8 = 1'b1; a8 = 8'h55; b8 = 8'hAA;
            end
            @(posedge clk); #1;
            checks++; if (done8 !== (c % 10 == 9)) begin failures++;
                $display("FAIL b2b_done cycle=%0d got=%b exp=%b", c, done8, (c % 10 == 9)); end
            if (c % 10 == 9) begin
                checks++; if (product8 !== op[c/10]) begin failures++;
                    $display("FAIL b2b_product op=%0d got=%h exp=%h", c/10, product8, op[c/10]);
                end
            end
        end
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic test_reset_abort;
        logic [15:0] p; int lat; logic bd; int pulses;
        @(negedge clk);
        start8 = 1'b1; sm8 = 1'b1; a8 = 8'h03; b8 = 8'h07;
        @(posedge clk); #1;
        start8 = 1'b0;
        checks++; if (busy8 !== 1'b1 || ready8 !== 1'b0) begin failures++;
            $display("FAIL calc_busy got=%b/%b exp=1/0", busy8, ready8); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (product8 !== 16'h0000) begin failures++;
            $display("FAIL abort_product got=%h exp=0000", product8); end
        checks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin failures++;
            $display("FAIL abort_flags got=%b/%b exp=0/0", busy8, done8); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done8) pulses++;
        end
        checks++; if (pulses != 0) begin failures++;
            $display("FAIL abort_no_done got=%0d exp=0", pulses); end
        run8(1'b0, 8'h06, 8'h07, p, lat, bd);
        checks++; if (p !== 16'h002A) begin failures++;
            $display("FAIL after_abort_product got=%h exp=002a", p); end
    endtask

    task automatic test_w16_sweep;
        logic        dsm[4];
        logic [15:0] da[4];
        logic [15:0] db[4];
        logic [31:0] dex[4];
        dsm = '{1'b1, 1'b0, 1'b1, 1'b0};
        da  = '{16'h8000, 16'hFFFF, 16'hFFFF, 16'h8000};
        db  = '{16'h8000, 16'hFFFF, 16'h0001, 16'h0002};
        dex = '{32'h40000000, 32'hFFFE0001, 32'hFFFFFFFF, 32'h00010000};
        for (int i = 0; i < 16; i++) begin
            logic sm; logic [15:0] av, bv; logic [31:0] ex, p; int lat;
            if (i < 4) begin
                sm = dsm[i]; av = da[i]; bv = db[i]; ex = dex[i];
            end else begin
                sm = 1'($urandom); av = 16'($urandom); bv = 16'($urandom);
                // Low 32 bits of the 32x32 product of the extended operands.
                if (sm) ex = {{16{av[15]}}, av} * {{16{bv[15]}}, bv};
                else    ex = {16'h0000, av} * {16'h0000, bv};
            end
            run16(sm, av, bv, p, lat);
            checks++; if (p !== ex) begin failures++;
                $display("FAIL w16_%0d sm=%b a=%h b=%h got=%h exp=%h", i, sm, av, bv, p, ex); end
`ifndef ALU_MUL_EARLY_TERM_EN
            checks++; if (lat != 17) begin failures++;
                $display("FAIL w16_%0d_latency got=%0d exp=17", i, lat); end
`endif
        end
    endtask

`ifdef ALU_MUL_EARLY_TERM_EN
    task automatic test_early_term;
        logic [15:0] p; int lat; logic bd;
        run8(1'b1, 8'h37, 8'h00, p, lat, bd);
        checks++; if (lat != 1 || p !== 16'h0000) begin failures++;
            $display("FAIL early_b0 lat=%0d p=%h exp lat=1 p=0000", lat, p); end
        run8(1'b0, 8'h5A, 8'h01, p, lat, bd);
        checks++; if (lat != 2 || p !== 16'h005A) begin failures++;
            $display("FAIL early_b1 lat=%0d p=%h exp lat=2 p=005a", lat, p); end
    endtask
`endif

    initial begin
        test_reset();
        test_signed_basic();
        test_extremes();
`ifndef ALU_MUL_EARLY_TERM_EN
        test_back_to_back();
`else
        test_early_term();
`endif
        test_reset_abort();
        test_w16_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
